// File: rtl/digi_ota_array.sv
// digi_ota_array: multi-channel clocked digital OTA.
// Each channel resynchronises an asynchronous vip/vin pair. It integrates
// sign(vip - vin) in a saturating signed counter and drives a hysteretic
// comparator output with a registered drive enable.
//
// Ports:
//   clk, rst_n     single clock, synchronous active-low reset
//   ena            update enable (freezes cnt/out/out_oe/prescaler when low)
//   vip, vin       [CHANNELS] asynchronous differential inputs
//   out, out_oe    [CHANNELS] comparator output and drive enable
//   rd_sel, rd_cnt readout mux; rd_cnt is the registered cnt of rd_sel,
//                  or 0 when rd_sel >= CHANNELS
//
// Optional feature macro: DIGI_OTA_LEAK_EN. When it is defined, a shared
// prescaler ticks every LEAK_DIV enabled cycles. On each tick, idle channels
// (diff == 0) move their counter one step toward zero.

module digi_ota_lane #(
  parameter int CNT_W = 6,
  parameter int HYST  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
`ifdef DIGI_OTA_LEAK_EN
  input  logic                    tick,
`endif
  input  logic                    vip,
  input  logic                    vin,
  output logic                    out,
  output logic                    out_oe,
  output logic signed [CNT_W-1:0] cnt
);
  localparam logic signed [CNT_W-1:0] CNT_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] CNT_MIN = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic signed [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic signed [CNT_W-1:0] HYST_P  = CNT_W'(HYST);
  localparam logic signed [CNT_W-1:0] HYST_N  = -HYST_P;

  logic [1:0] vip_sync, vin_sync;
  logic       vip_s, vin_s, up, dn;
  logic signed [CNT_W-1:0] cnt_n;

  assign vip_s = vip_sync[1];
  assign vin_s = vin_sync[1];
  assign up    = vip_s & ~vin_s;
  assign dn    = ~vip_s & vin_s;

  // Next-state counter. A nonzero diff always wins over the leak step.
  always_comb begin
    cnt_n = cnt;
    if (up) begin
      if (cnt != CNT_MAX) cnt_n = cnt + ONE;
    end else if (dn) begin
      if (cnt != CNT_MIN) cnt_n = cnt - ONE;
    end
`ifdef DIGI_OTA_LEAK_EN
    else if (tick && cnt != '0) begin
      cnt_n = cnt[CNT_W-1] ? cnt + ONE : cnt - ONE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vip_sync <= '0;
      vin_sync <= '0;
      cnt      <= '0;
      out      <= 1'b0;
      out_oe   <= 1'b0;
    end else begin
      vip_sync <= {vip_sync[0], vip};
      vin_sync <= {vin_sync[0], vin};
      if (ena) begin
        cnt    <= cnt_n;
        out_oe <= vip_s ^ vin_s;
        // The comparator looks at the value being written, so out moves on
        // the same edge as cnt. Inside the band it holds.
        if (cnt_n >= HYST_P)      out <= 1'b1;
        else if (cnt_n <= HYST_N) out <= 1'b0;
      end
    end
  end
endmodule

module digi_ota_array #(
  parameter  int CHANNELS = 4,
  parameter  int CNT_W    = 6,
  parameter  int HYST     = 4,
  parameter  int LEAK_DIV = 16,
  localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [CHANNELS-1:0] vip,
  input  logic [CHANNELS-1:0] vin,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] out_oe,
  input  logic [SEL_W-1:0]    rd_sel,
  output logic [CNT_W-1:0]    rd_cnt
);
  // Elaboration-time parameter guards.
  if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_ch
    $error("digi_ota_array: CHANNELS out of range");
  end
  if (CNT_W < 3 || CNT_W > 12) begin : g_bad_w
    $error("digi_ota_array: CNT_W out of range");
  end
  if (HYST < 1 || HYST > (1 << (CNT_W-1)) - 1) begin : g_bad_h
    $error("digi_ota_array: HYST out of range");
  end
  if (LEAK_DIV < 2) begin : g_bad_l
    $error("digi_ota_array: LEAK_DIV must be >= 2");
  end

  logic [CHANNELS-1:0][CNT_W-1:0] cnt_all;

`ifdef DIGI_OTA_LEAK_EN
  localparam int PW = $clog2(LEAK_DIV);
  logic [PW-1:0] presc;
  logic          tick;

  // The prescaler freezes together with the integrators.
  assign tick = ena && (presc == PW'(LEAK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)   presc <= '0;
    else if (ena) presc <= tick ? '0 : presc + 1'b1;
  end
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    digi_ota_lane #(.CNT_W(CNT_W), .HYST(HYST)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena),
`ifdef DIGI_OTA_LEAK_EN
      .tick   (tick),
`endif
      .vip    (vip[g]),
      .vin    (vin[g]),
      .out    (out[g]),
      .out_oe (out_oe[g]),
      .cnt    (cnt_all[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                       rd_cnt <= '0;
    else if (int'(rd_sel) < CHANNELS) rd_cnt <= cnt_all[rd_sel];
    else                              rd_cnt <= '0;
  end
endmodule

// File: tb/tb_digi_ota_array.sv
// Scoreboard bench for digi_ota_array. Stimulus pushes expected values tagged
// with the clock edge after which they must hold. A monitor checks them 1 time
// unit after each rising edge. A 3-channel instance checks out-of-range
// readout.
module tb_digi_ota_array;
  logic       clk = 1'b0;
  logic       rst_n, ena;
  logic [3:0] vip, vin, out, out_oe;
  logic [1:0] rd_sel;
  logic [5:0] rd_cnt;
  logic [2:0] out3, out_oe3;
  logic [5:0] rd_cnt3;

  always #5 clk = ~clk;

  digi_ota_array #(.CHANNELS(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .vip(vip), .vin(vin),
    .out(out), .out_oe(out_oe), .rd_sel(rd_sel), .rd_cnt(rd_cnt));

  digi_ota_array #(.CHANNELS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .vip(vip[2:0]), .vin(vin[2:0]),
    .out(out3), .out_oe(out_oe3), .rd_sel(rd_sel), .rd_cnt(rd_cnt3));

  typedef struct {
    int    cyc;
    int    kind;  // 0 out bit, 1 out_oe bit, 2 rd_cnt, 3 rd_cnt3, 4 out vec, 5 out_oe vec
    int    ch;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];
  int   edges  = 0;
  int   passed = 0;
  int   total  = 0;

  task automatic expect_at(input int cyc, input int kind, input int ch,
                           input int val, input string name);
    exp_t e;
    e.cyc = cyc; e.kind = kind; e.ch = ch; e.val = val; e.name = name;
    sb.push_back(e);
  endtask

  function automatic int sample(input int kind, input int ch);
    int v;
    case (kind)
      0: v = int'(out[ch]);
      1: v = int'(out_oe[ch]);
      2: v = $signed(rd_cnt);
      3: v = $signed(rd_cnt3);
      4: v = int'(out);
      default: v = int'(out_oe);
    endcase
    return v;
  endfunction

  // Monitor: compare every expectation that is due after this edge.
  always @(posedge clk) begin
    edges++;
    #1;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == edges) begin
        int act;
        act = sample(sb[i].kind, sb[i].ch);
        total++;
        if (act == sb[i].val) passed++;
        else $display("FAIL %s @edge %0d: got %0d expected %0d",
                      sb[i].name, edges, act, sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic wait_to(input int e);
    while (edges < e) @(negedge clk);
  endtask

  int k, m, p, q, r, s, base, reach20;

  initial begin
    rst_n = 1'b0; ena = 1'b1; rd_sel = 2'd0;
    vip = 4'($urandom); vin = 4'($urandom);
    @(negedge clk);
    // Reset held across two edges with random inputs.
    expect_at(edges + 1, 4, 0, 0, "rst_out");
    expect_at(edges + 1, 5, 0, 0, "rst_oe");
    expect_at(edges + 1, 2, 0, 0, "rst_rd");
    expect_at(edges + 1, 3, 0, 0, "rst_rd3");
    wait_to(edges + 1);
    total++;
    if (out == 4'd0) passed++;
    else $display("FAIL rst_out_direct: got %0h", out);
    total++;
    if (out_oe == 4'd0) passed++;
    else $display("FAIL rst_oe_direct: got %0h", out_oe);
    total++;
    if (rd_cnt == 6'd0) passed++;
    else $display("FAIL rst_rd_direct: got %0d", rd_cnt);
    total++;
    if (rd_cnt3 == 6'd0) passed++;
    else $display("FAIL rst_rd3_direct: got %0d", rd_cnt3);
    rst_n = 1'b1; vip = '0; vin = '0;

    // Step up on ch0.
    k = edges;
    vip[0] = 1'b1;
    expect_at(k + 2,  1, 0, 0,  "step_oe_pre");
    expect_at(k + 3,  1, 0, 1,  "step_oe");
    expect_at(k + 3,  2, 0, 0,  "step_rd0");
    expect_at(k + 4,  2, 0, 1,  "step_rd1");
    expect_at(k + 5,  0, 0, 0,  "step_out_pre");
    expect_at(k + 6,  0, 0, 1,  "step_out");
    expect_at(k + 33, 2, 0, 30, "step_rd30");
    expect_at(k + 34, 2, 0, 31, "step_sat");
    expect_at(k + 40, 2, 0, 31, "step_sat_hold");
    wait_to(k + 40);
    vip[0] = 1'b0;
    expect_at(k + 42, 1, 0, 1,  "idle_oe_pre");
    expect_at(k + 43, 1, 0, 0,  "idle_oe");
    expect_at(k + 43, 0, 0, 1,  "idle_out_hold");
    wait_to(k + 44);

    // Hysteresis on ch1: ramp to +10, then drive down.
    m = edges;
    rd_sel = 2'd1;
    vip[1] = 1'b1;
    expect_at(m + 5, 0, 1, 0, "hyst_out_pre");
    expect_at(m + 6, 0, 1, 1, "hyst_out_rise");
    wait_to(m + 10);
    vip[1] = 1'b0; vin[1] = 1'b1;
    expect_at(m + 13, 2, 1, 10,  "hyst_peak");
    expect_at(m + 25, 0, 1, 1,   "hyst_hold_m3");
    expect_at(m + 26, 2, 1, -3,  "hyst_rd_m3");
    expect_at(m + 26, 0, 1, 0,   "hyst_fall_m4");
    expect_at(m + 26, 1, 1, 1,   "hyst_oe");
    expect_at(m + 27, 2, 1, -4,  "hyst_rd_m4");
    expect_at(m + 54, 2, 1, -31, "hyst_rd_m31");
    expect_at(m + 55, 2, 1, -32, "hyst_sat");
    expect_at(m + 60, 2, 1, -32, "hyst_sat_hold");
    wait_to(m + 60);

    // Out-of-range readout on the 3-channel instance.
    rd_sel = 2'd3;
    expect_at(m + 61, 3, 3, 0, "rd_oor");
    wait_to(m + 61);
    rd_sel = 2'd1;
    expect_at(m + 62, 3, 1, -32, "rd3_ch1");
    wait_to(m + 62);

    // Enable freeze on ch2 at cnt=7.
    p = edges;
    rd_sel = 2'd2;
    vip[2] = 1'b1;
    expect_at(p + 6, 0, 2, 1, "frz_out");
    wait_to(p + 9);
    ena = 1'b0;
    expect_at(p + 10, 2, 2, 7, "frz_rd_a");
    expect_at(p + 20, 1, 2, 1, "frz_oe");
    expect_at(p + 20, 0, 2, 1, "frz_out_hold");
    expect_at(p + 20, 1, 0, 0, "frz_oe_ch0");
    expect_at(p + 29, 2, 2, 7, "frz_rd_b");
    wait_to(p + 29);
    ena = 1'b1;
    expect_at(p + 30, 2, 2, 7, "frz_rd_c");
    expect_at(p + 31, 2, 2, 8, "frz_resume");
    wait_to(p + 31);
    vip[2] = 1'b0;

    // Idle hold (or leak) on ch3 at cnt=5.
    q = edges;
    rd_sel = 2'd3;
    vip[3] = 1'b1;
    wait_to(q + 5);
    vin[3] = 1'b1;
    expect_at(q + 7, 1, 3, 1, "leak_oe_pre");
    expect_at(q + 8, 1, 3, 0, "leak_oe");
    expect_at(q + 8, 2, 3, 5, "leak_rd5");
`ifdef DIGI_OTA_LEAK_EN
    expect_at(q + 90,  2, 3, 0, "leak_zero");
    expect_at(q + 100, 2, 3, 0, "leak_zero_hold");
    base = 0;
`else
    expect_at(q + 90,  2, 3, 5, "noleak_hold");
    expect_at(q + 90,  0, 3, 1, "noleak_out");
    base = 5;
`endif
    wait_to(q + 100);

    // Mid-run reset with ch3 at cnt=20.
    r = edges;
    vin[3] = 1'b0;
    reach20 = r + 2 + (20 - base);
    expect_at(reach20,     2, 3, 19, "mid_rd19");
    expect_at(reach20 + 1, 2, 3, 0,  "mid_rst_rd");
    expect_at(reach20 + 1, 4, 0, 0,  "mid_rst_out");
    expect_at(reach20 + 1, 5, 0, 0,  "mid_rst_oe");
    wait_to(reach20);
    rst_n = 1'b0;
    wait_to(reach20 + 1);
    rst_n = 1'b1; vip = '0; vin = '0; rd_sel = 2'd0;
    s = edges;
    vip[0] = 1'b1;
    expect_at(s + 1, 2, 0, 0, "post_rst_rd");
    expect_at(s + 3, 2, 0, 0, "post_rst_rd_pre");
    expect_at(s + 3, 1, 0, 1, "post_rst_oe");
    expect_at(s + 4, 2, 0, 1, "post_rst_first");

    // Drain the scoreboard with a bound; leftovers count as failures.
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    foreach (sb[i]) begin
      total++;
      $display("FAIL %s: never checked (due edge %0d)", sb[i].name, sb[i].cyc);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
